fc_layer_sequencer: RTL and testbench

- Parametrised controller for an N-layer fully-connected classifier: one shared weight/input address counter, per-layer reset, and ReLU enable for the layer and activation instances.
- Adds a start/busy/done handshake, abort, and a sequential argmax over the final logits with a registered class output.
- Sits between the conv/pool front end (which raises start once flattened features are stable) and the layer, activationFunction and weightMemory instances.

---
 rtl/fc_seq_pkg.sv | 33 +++
 rtl/fc_argmax_seq.sv | 34 +++
 rtl/fc_layer_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fc_seq_pkg.sv
// Shared types and compile-time helpers for the fully-connected layer sequencer.
// Node counts are packed 16 bits per entry, entry 0 in the LSBs.
package fc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_SETTLE,
    S_RELU,
    S_ARGMAX,
    S_DONE
  } state_t;

  localparam int MAX_LAYERS = 8;
  localparam int PACK_W     = 16 * (MAX_LAYERS + 1);

  localparam logic [79:0] DEFAULT_LAYER_NODES =
    {16'd10, 16'd84, 16'd120, 16'd120, 16'd288};

  function automatic logic [15:0] node_count(input logic [PACK_W-1:0] nodes, input int i);
    return nodes[16*i +: 16];
  endfunction

  // Cycles from the start-sampling edge to the done pulse, counting CLEAR as cycle 1.
  function automatic int latency(input logic [PACK_W-1:0] nodes, input int num_layers);
    int t;
    t = 0;
    for (int l = 0; l < num_layers; l++) t += int'(node_count(nodes, l)) + 2;
    return t + (num_layers - 1) + int'(node_count(nodes, num_layers)) + 1;
  endfunction

endpackage

// File: rtl/fc_argmax_seq.sv
// Sequential signed argmax: one candidate per step, strict-greater replacement so
// ties keep the earliest index. clear with step loads the first candidate unconditionally.
module fc_argmax_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int CLASS_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          step,
  input  logic signed [DATA_WIDTH-1:0]  value,
  input  logic        [CLASS_WIDTH-1:0] index,
  output logic        [CLASS_WIDTH-1:0] best_idx,
  output logic signed [DATA_WIDTH-1:0]  best_val
);

  logic take;

  assign take = step && (clear || (value > best_val));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_idx <= '0;
    end else if (take) begin
      best_idx <= index;
    end
  end

  // Data register: only meaningful after a clear, so it carries no reset.
  always_ff @(posedge clk) begin
    if (take) best_val <= value;
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Controller for an N-layer FC classifier: shared address counter, layer/ReLU control,
// start/busy/done handshake, abort and a sequential argmax over the final logits.
// Define FC_SEQ_PERF_EN to add the cycle_count/run_count performance counters.
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int                           DATA_WIDTH  = 32,
  parameter int                           NUM_LAYERS  = 4,
  parameter logic [16*(NUM_LAYERS+1)-1:0] LAYER_NODES = DEFAULT_LAYER_NODES,
  parameter int                           ADDR_WIDTH  = 11,
  parameter int                           OUT_NODES   = int'(LAYER_NODES[16*NUM_LAYERS +: 16]),
  parameter int                           CLASS_WIDTH = (OUT_NODES > 1) ? $clog2(OUT_NODES) : 1,
  parameter int                           LSEL_WIDTH  = $clog2(NUM_LAYERS) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [DATA_WIDTH*OUT_NODES-1:0] logits,
  output logic                            busy,
  output logic                            done,
  output logic [LSEL_WIDTH-1:0]           layer_sel,
  output logic [ADDR_WIDTH-1:0]           address,
  output logic                            layer_rst,
  output logic                            relu_rst,
  output logic                            relu_en,
  output logic [CLASS_WIDTH-1:0]          class_idx,
  output logic                            class_valid
`ifdef FC_SEQ_PERF_EN
  ,
  output logic [31:0]                     cycle_count,
  output logic [15:0]                     run_count
`endif
);

  localparam logic [PACK_W-1:0]      NODES_EXT  = PACK_W'(LAYER_NODES);
  localparam logic [LSEL_WIDTH-1:0]  LAST_LAYER = LSEL_WIDTH'(NUM_LAYERS - 1);
  localparam logic [CLASS_WIDTH-1:0] LAST_CLASS = CLASS_WIDTH'(OUT_NODES - 1);

  state_t                         state, state_next;
  logic        [LSEL_WIDTH-1:0]   layer_sel_next;
  logic        [ADDR_WIDTH-1:0]   address_next;
  logic        [ADDR_WIDTH-1:0]   layer_len;
  logic        [CLASS_WIDTH-1:0]  scan_idx, scan_next;
  logic        [CLASS_WIDTH-1:0]  best_idx;
  logic signed [DATA_WIDTH-1:0]   best_val;
  logic signed [DATA_WIDTH-1:0]   scan_val;
  logic                           start_take, abort_take;
  logic                           scan_first, scan_step, scan_last;

  assign layer_len  = ADDR_WIDTH'(node_count(NODES_EXT, int'(layer_sel)));
  assign start_take = (state == S_IDLE) && start && !abort;
  assign abort_take = (state != S_IDLE) && abort;
  assign scan_val   = logits[int'(scan_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign scan_step  = (state == S_ARGMAX) && !abort_take;
  assign scan_first = scan_step && (scan_idx == '0);
  assign scan_last  = scan_step && (scan_idx == LAST_CLASS);

  always_comb begin
    state_next     = state;
    layer_sel_next = layer_sel;
    address_next   = address;
    scan_next      = scan_idx;
    if (abort_take) begin
      state_next   = S_IDLE;
      address_next = '0;
      scan_next    = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_take) begin
            state_next     = S_CLEAR;
            layer_sel_next = '0;
            address_next   = '0;
          end
        end
        S_CLEAR: begin
          state_next   = S_ACCUM;
          address_next = '0;
        end
        S_ACCUM: begin
          // Park the address at N in SETTLE so no accumulator sees a fresh term.
          if (address == layer_len - ADDR_WIDTH'(1)) begin
            state_next   = S_SETTLE;
            address_next = layer_len;
          end else begin
            address_next = address + ADDR_WIDTH'(1);
          end
        end
        S_SETTLE: begin
          if (layer_sel < LAST_LAYER) begin
            state_next = S_RELU;
          end else begin
            state_next = S_ARGMAX;
            scan_next  = '0;
          end
        end
        S_RELU: begin
          state_next     = S_CLEAR;
          layer_sel_next = layer_sel + LSEL_WIDTH'(1);
          address_next   = '0;
        end
        S_ARGMAX: begin
          if (scan_idx == LAST_CLASS) state_next = S_DONE;
          else                        scan_next  = scan_idx + CLASS_WIDTH'(1);
        end
        S_DONE: begin
          state_next   = S_IDLE;
          address_next = '0;
          scan_next    = '0;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      layer_sel   <= '0;
      address     <= '0;
      scan_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      layer_rst   <= 1'b1;
      relu_rst    <= 1'b1;
      relu_en     <= 1'b0;
      class_idx   <= '0;
      class_valid <= 1'b0;
    end else begin
      state     <= state_next;
      layer_sel <= layer_sel_next;
      address   <= address_next;
      scan_idx  <= scan_next;
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_DONE);
      relu_en   <= (state_next == S_RELU);
      layer_rst <= abort_take || (state_next == S_CLEAR);
      relu_rst  <= abort_take || ((state_next == S_CLEAR) && (layer_sel_next == '0));
      if (scan_last) begin
        class_idx <= (scan_first || (scan_val > best_val)) ? scan_idx : best_idx;
      end
      if (start_take || abort_take) class_valid <= 1'b0;
      else if (state_next == S_DONE) class_valid <= 1'b1;
    end
  end

  fc_argmax_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLASS_WIDTH(CLASS_WIDTH)
  ) u_argmax (
    .clk     (clk),
    .reset   (reset),
    .clear   (scan_first),
    .step    (scan_step),
    .value   (scan_val),
    .index   (scan_idx),
    .best_idx(best_idx),
    .best_val(best_val)
  );

`ifdef FC_SEQ_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // cycle_count equals the number of busy cycles so far, including the current one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      run_count   <= '0;
    end else begin
      if (start_take) cycle_count <= 32'd1;
      else if ((state != S_IDLE) && (state_next != S_IDLE)) cycle_count <= sat_inc32(cycle_count);
      if (state_next == S_DONE) run_count <= run_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer: default 4-layer build plus a 2-layer instance.
module tb_fc_layer_sequencer;
  import fc_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [319:0] logits_a = '0;
  logic [63:0]  logits_b = {32'd5, 32'hFFFF_FFFF};

  logic         busy_a, done_a, lrst_a, rrst_a, ren_a, cv_a;
  logic [2:0]   lsel_a;
  logic [10:0]  addr_a;
  logic [3:0]   cls_a;
  logic         busy_b, done_b, lrst_b, rrst_b, ren_b, cv_b;
  logic [1:0]   lsel_b;
  logic [10:0]  addr_b;
  logic [0:0]   cls_b;
`ifdef FC_SEQ_PERF_EN
  logic [31:0]  cc_a, cc_b;
  logic [15:0]  rc_a, rc_b;
`endif

  int checks = 0;
  int failures = 0;

  fc_layer_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .logits(logits_a),
    .busy(busy_a), .done(done_a), .layer_sel(lsel_a), .address(addr_a),
    .layer_rst(lrst_a), .relu_rst(rrst_a), .relu_en(ren_a),
    .class_idx(cls_a), .class_valid(cv_a)
`ifdef FC_SEQ_PERF_EN
    , .cycle_count(cc_a), .run_count(rc_a)
`endif
  );

  fc_layer_sequencer #(
    .NUM_LAYERS (2),
    .LAYER_NODES({16'd2, 16'd3, 16'd4})
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .logits(logits_b),
    .busy(busy_b), .done(done_b), .layer_sel(lsel_b), .address(addr_b),
    .layer_rst(lrst_b), .relu_rst(rrst_b), .relu_en(ren_b),
    .class_idx(cls_b), .class_valid(cv_b)
`ifdef FC_SEQ_PERF_EN
    , .cycle_count(cc_b), .run_count(rc_b)
`endif
  );

  // Observations recorded by the run tasks.
  int         done_cyc, done_cnt, relu_cnt;
  int         lsel_seq[$];
  logic [3:0] cls_done;
  logic       cv_done, busy_after, cv_end;
  logic       post_busy, post_lrst, post_rrst, post_cv, post2_lrst, post2_rrst;
  int         addr_log[0:24];
  logic       ren_log[0:24];
  logic       done_log[0:24];
  int         lsel_log[0:24];
  logic [0:0] cls_b_done;

  task automatic set_logits_a(input logic [31:0] fill, input int i1, input logic [31:0] v1,
                              input int i2, input logic [31:0] v2);
    for (int k = 0; k < 10; k++) logits_a[k*32 +: 32] = fill;
    if (i1 >= 0) logits_a[i1*32 +: 32] = v1;
    if (i2 >= 0) logits_a[i2*32 +: 32] = v2;
  endtask

  // Pulse start, then observe ncyc cycles; cycle 1 is the one right after the sampling edge.
  task automatic run_a(input int ncyc, input int abort_at, input int re1, input int re2);
    done_cyc = -1; done_cnt = 0; relu_cnt = 0; lsel_seq.delete();
    busy_after = 1'bx;
    @(negedge clk); start_a = 1'b1; abort_a = 1'b0;
    @(negedge clk); start_a = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (done_cyc > 0 && c == done_cyc + 1) busy_after = busy_a;
      if (done_a) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; cls_done = cls_a; cv_done = cv_a; end
      end
      if (ren_a) relu_cnt++;
      if (lrst_a && busy_a) lsel_seq.push_back(int'(lsel_a));
      if (c == abort_at + 1) begin post_busy = busy_a; post_lrst = lrst_a; post_rrst = rrst_a; post_cv = cv_a; end
      if (c == abort_at + 2) begin post2_lrst = lrst_a; post2_rrst = rrst_a; end
      abort_a = (c == abort_at);
      start_a = (c == re1) || (c == re2);
      @(negedge clk);
    end
    abort_a = 1'b0; start_a = 1'b0;
    cv_end = cv_a;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_a = 1'b0; abort_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy_a, done_a, ren_a, cv_a} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy_a, done_a, ren_a, cv_a}); end
    checks++; if ({lrst_a, rrst_a} !== 2'b11) begin failures++; $display("FAIL reset_rst got=%b exp=11", {lrst_a, rrst_a}); end
    checks++; if ({lsel_a, addr_a, cls_a} !== '0) begin failures++; $display("FAIL reset_regs got lsel=%0d addr=%0d cls=%0d exp=0", lsel_a, addr_a, cls_a); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({lrst_a, rrst_a} !== 2'b00) begin failures++; $display("FAIL idle_rst got=%b exp=00", {lrst_a, rrst_a}); end
    checks++; if (latency(PACK_W'(DEFAULT_LAYER_NODES), 4) !== 634) begin failures++; $display("FAIL pkg_latency got=%0d exp=634", latency(PACK_W'(DEFAULT_LAYER_NODES), 4)); end
  endtask

  task automatic test_default_run();
    set_logits_a(32'hFFFF_FF00, 7, 32'h0000_0100, -1, '0);
    run_a(640, 0, 0, 0);
    checks++; if (done_cyc !== 634) begin failures++; $display("FAIL default_latency got=%0d exp=634", done_cyc); end
    checks++; if (cls_done !== 4'd7) begin failures++; $display("FAIL default_class got=%0d exp=7", cls_done); end
    checks++; if (cv_done !== 1'b1) begin failures++; $display("FAIL default_valid got=%b exp=1", cv_done); end
    checks++; if (relu_cnt !== 3) begin failures++; $display("FAIL relu_pulses got=%0d exp=3", relu_cnt); end
    checks++; if (lsel_seq.size() !== 4) begin failures++; $display("FAIL lsel_count got=%0d exp=4", lsel_seq.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= lsel_seq.size() || lsel_seq[i] !== i) begin
        failures++; $display("FAIL lsel_seq[%0d] got=%0d exp=%0d", i, (i < lsel_seq.size()) ? lsel_seq[i] : -1, i);
      end
    end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL busy_after_done got=%b exp=0", busy_after); end
    checks++; if (cv_end !== 1'b1 || cls_a !== 4'd7) begin failures++; $display("FAIL class_hold got valid=%b cls=%0d exp valid=1 cls=7", cv_end, cls_a); end
`ifdef FC_SEQ_PERF_EN
    checks++; if (cc_a !== 32'd634) begin failures++; $display("FAIL perf_cycles got=%0d exp=634", cc_a); end
    checks++; if (rc_a !== 16'd1) begin failures++; $display("FAIL perf_runs got=%0d exp=1", rc_a); end
`endif
  endtask

  task automatic test_small_cfg();
    int exp_c[9] = '{2, 3, 4, 5, 6, 9, 10, 11, 12};
    int exp_v[9] = '{0, 1, 2, 3, 4, 0, 1, 2, 3};
    int first_done, ren_cnt;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      addr_log[c] = int'(addr_b); ren_log[c] = ren_b; done_log[c] = done_b; lsel_log[c] = int'(lsel_b);
      if (done_b) cls_b_done = cls_b;
      @(negedge clk);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (addr_log[exp_c[i]] !== exp_v[i]) begin failures++; $display("FAIL small_addr cyc%0d got=%0d exp=%0d", exp_c[i], addr_log[exp_c[i]], exp_v[i]); end
    end
    first_done = -1; ren_cnt = 0;
    for (int c = 20; c >= 1; c--) begin
      if (done_log[c]) first_done = c;
      if (ren_log[c]) ren_cnt++;
    end
    checks++; if (first_done !== 15) begin failures++; $display("FAIL small_latency got=%0d exp=15", first_done); end
    checks++; if (ren_log[7] !== 1'b1 || ren_cnt !== 1) begin failures++; $display("FAIL small_relu got cyc7=%b count=%0d exp 1/1", ren_log[7], ren_cnt); end
    checks++; if (lsel_log[8] !== 1) begin failures++; $display("FAIL small_lsel got=%0d exp=1", lsel_log[8]); end
    checks++; if (cls_b_done !== 1'b1) begin failures++; $display("FAIL small_class got=%0d exp=1", cls_b_done); end
  endtask

  task automatic test_abort();
    run_a(700, 300, 0, 0);
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
    checks++; if (post_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", post_busy); end
    checks++; if ({post_lrst, post_rrst} !== 2'b11) begin failures++; $display("FAIL abort_rst got=%b exp=11", {post_lrst, post_rrst}); end
    checks++; if ({post2_lrst, post2_rrst} !== 2'b00) begin failures++; $display("FAIL abort_rst_end got=%b exp=00", {post2_lrst, post2_rrst}); end
    checks++; if (post_cv !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", post_cv); end
`ifdef FC_SEQ_PERF_EN
    checks++; if (cc_a !== 32'd300) begin failures++; $display("FAIL perf_abort_cycles got=%0d exp=300", cc_a); end
`endif
    run_a(640, 0, 0, 0);
    checks++; if (done_cyc !== 634 || cls_done !== 4'd7) begin failures++; $display("FAIL rerun got lat=%0d cls=%0d exp 634/7", done_cyc, cls_done); end
`ifdef FC_SEQ_PERF_EN
    checks++; if (rc_a !== 16'd2 || cc_a !== 32'd634) begin failures++; $display("FAIL perf_second got runs=%0d cycles=%0d exp 2/634", rc_a, cc_a); end
`endif
  endtask

  task automatic test_abort_idle();
    @(negedge clk); start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk); start_a = 1'b0; abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_over_start got busy=%b exp=0", busy_a); end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (busy_a && addr_a == 11'd50) found = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!found) begin failures++; $display("FAIL reach_addr50 got=%0d exp=50", addr_a); end
    reset = 1'b1; start_a = 1'b1;
    #1;
    checks++; if ({busy_a, done_a, ren_a, cv_a, lrst_a, rrst_a} !== 6'b000011) begin failures++; $display("FAIL mid_reset_flags got=%b exp=000011", {busy_a, done_a, ren_a, cv_a, lrst_a, rrst_a}); end
    checks++; if ({lsel_a, addr_a, cls_a} !== '0) begin failures++; $display("FAIL mid_reset_regs got lsel=%0d addr=%0d cls=%0d exp=0", lsel_a, addr_a, cls_a); end
    repeat (3) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL start_in_reset got busy=%b exp=0", busy_a); end
    reset = 1'b0; start_a = 1'b0;
    @(negedge clk);
    checks++; if ({busy_a, lrst_a, rrst_a} !== 3'b000) begin failures++; $display("FAIL after_reset got=%b exp=000", {busy_a, lrst_a, rrst_a}); end
  endtask

  task automatic test_tie();
    set_logits_a(32'h8000_0000, 2, 32'h7FFF_FFFF, 5, 32'h7FFF_FFFF);
    run_a(640, 0, 0, 0);
    checks++; if (cls_done !== 4'd2) begin failures++; $display("FAIL tie_class got=%0d exp=2", cls_done); end
    set_logits_a(32'h0000_0000, 9, 32'h0000_0001, -1, '0);
    run_a(640, 0, 0, 0);
    checks++; if (cls_done !== 4'd9) begin failures++; $display("FAIL last_class got=%0d exp=9", cls_done); end
    set_logits_a(32'h8000_0000, -1, '0, -1, '0);
    run_a(640, 0, 0, 0);
    checks++; if (cls_done !== 4'd0 || cv_done !== 1'b1) begin failures++; $display("FAIL min_class got cls=%0d valid=%b exp 0/1", cls_done, cv_done); end
  endtask

  task automatic test_back_to_back();
    set_logits_a(32'hFFFF_FF00, 3, 32'h0000_0010, -1, '0);
    run_a(700, 0, 10, 634);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL busy_start_dones got=%0d exp=1", done_cnt); end
    checks++; if (done_cyc !== 634 || cls_done !== 4'd3) begin failures++; $display("FAIL busy_start_run got lat=%0d cls=%0d exp 634/3", done_cyc, cls_done); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_default_run();
    test_small_cfg();
    test_abort();
    test_abort_idle();
    test_reset_mid();
    test_tie();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
